// File: rtl/snake_body_if.sv
// Handshake/bus bundle between the game logic, the renderer and snake_body.
// master drives tick/direction/grow/queries; slave (snake_body) returns state.
interface snake_body_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 5
);
  logic          tick;
  logic [1:0]    direction;
  logic          grow;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          game_over;
  logic          moved;
  logic [XW-1:0] query_x;
  logic [YW-1:0] query_y;
  logic          query_hit;
  logic          query_head;

  modport master (
    output tick, direction, grow, query_x, query_y,
    input  head_x, head_y, length, game_over, moved, query_hit, query_head
  );

  modport slave (
    input  tick, direction, grow, query_x, query_y,
    output head_x, head_y, length, game_over, moved, query_hit, query_head
  );
endinterface

// File: rtl/snake_body.sv
// Snake segment store: moves the head on each tick, shifts the body, grows on
// request, flags wall/self collisions and answers registered cell queries.
module snake_body #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 16,
  parameter int LW       = 5,
  parameter int INIT_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  snake_body_if.slave  bus
);

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len;
  logic          game_over_r;
  logic          moved_r;
  logic          grow_pend;
  logic          qhit_r;
  logic          qhead_r;

  dir_t          dir;
  logic [XW:0]   nxw;
  logic [YW:0]   nyw;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [LW-1:0] tail_idx;
  logic          wall;
  logic          self_hit;
  logic          growing;
  logic          full;
  logic          qhit_c;

  always_comb begin
    dir = dir_t'(bus.direction);
    nxw = {1'b0, seg_x[0]};
    nyw = {1'b0, seg_y[0]};
    // One extra bit: decrement from 0 wraps to the top of the widened range,
    // so a single unsigned bound check catches both edges.
    unique case (dir)
      UP:    nyw = {1'b0, seg_y[0]} - (YW+1)'(1);
      DOWN:  nyw = {1'b0, seg_y[0]} + (YW+1)'(1);
      LEFT:  nxw = {1'b0, seg_x[0]} - (XW+1)'(1);
      RIGHT: nxw = {1'b0, seg_x[0]} + (XW+1)'(1);
    endcase
    wall     = (nxw >= (XW+1)'(GRID_W)) || (nyw >= (YW+1)'(GRID_H));
    nx       = nxw[XW-1:0];
    ny       = nyw[YW-1:0];
    full     = (len == LW'(MAX_LEN));
    growing  = (grow_pend | bus.grow) & ~full;
    tail_idx = len - LW'(1);
    self_hit = 1'b0;
    qhit_c   = 1'b0;
    for (int unsigned j = 0; j < MAX_LEN; j++) begin
      // The tail only blocks the move when it will not vacate this tick.
      if (((LW'(j) < tail_idx) || (growing && (LW'(j) == tail_idx))) &&
          (seg_x[j] == nx) && (seg_y[j] == ny))
        self_hit = 1'b1;
      if ((LW'(j) < len) && (seg_x[j] == bus.query_x) && (seg_y[j] == bus.query_y))
        qhit_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2 + i) : '0;
      end
      len         <= LW'(INIT_LEN);
      game_over_r <= 1'b0;
      moved_r     <= 1'b0;
      grow_pend   <= 1'b0;
      qhit_r      <= 1'b0;
      qhead_r     <= 1'b0;
    end else begin
      moved_r <= 1'b0;
      qhit_r  <= qhit_c;
      qhead_r <= (seg_x[0] == bus.query_x) && (seg_y[0] == bus.query_y);
      if (bus.tick && !game_over_r) begin
        if (wall || self_hit) begin
          game_over_r <= 1'b1;
          grow_pend   <= (grow_pend | bus.grow) & ~full;
        end else begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0]  <= nx;
          seg_y[0]  <= ny;
          if (growing)
            len <= len + LW'(1);
          moved_r   <= 1'b1;
          grow_pend <= 1'b0;
        end
      end else if (bus.grow) begin
        grow_pend <= ~full;
      end
    end
  end

  assign bus.head_x     = seg_x[0];
  assign bus.head_y     = seg_y[0];
  assign bus.length     = len;
  assign bus.game_over  = game_over_r;
  assign bus.moved      = moved_r;
  assign bus.query_hit  = qhit_r;
  assign bus.query_head = qhead_r;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed scenarios then random play, every cycle
// compared against a queue-based snake model.
module tb_snake_body;
  localparam int W  = 32;
  localparam int H  = 24;
  localparam int ML = 16;
  localparam logic [1:0] U = 2'b00, D = 2'b01, L = 2'b10, R = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;

  snake_body_if #(.XW(5), .YW(5), .LW(5)) bus();

  snake_body #(
    .GRID_W(W), .GRID_H(H), .XW(5), .YW(5),
    .MAX_LEN(ML), .LW(5), .INIT_LEN(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: body[0] is the head, one entry per active segment, key = x*256+y.
  int body[$];
  bit m_go;
  bit m_pend;
  bit exp_mv;
  bit exp_qh;
  bit exp_qhd;

  function automatic int key(int x, int y);
    return x * 256 + y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("head_x", 32'(bus.head_x), 32'(body[0] / 256));
    chk("head_y", 32'(bus.head_y), 32'(body[0] % 256));
    chk("length", 32'(bus.length), 32'(body.size()));
    chk("game_over", 32'(bus.game_over), 32'(m_go));
    chk("moved", 32'(bus.moved), 32'(exp_mv));
    chk("query_hit", 32'(bus.query_hit), 32'(exp_qh));
    chk("query_head", 32'(bus.query_head), 32'(exp_qhd));
  endtask

  task automatic model_step(input bit t, input logic [1:0] d, input bit g);
    int  hx, hy, nx, ny, sz;
    bit  growing, full, hit;
    sz      = body.size();
    full    = (sz == ML);
    growing = (m_pend || g) && !full;
    exp_mv  = 1'b0;
    if (t && !m_go) begin
      hx = body[0] / 256;
      hy = body[0] % 256;
      nx = hx + ((d == R) ? 1 : (d == L) ? -1 : 0);
      ny = hy + ((d == D) ? 1 : (d == U) ? -1 : 0);
      hit = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
      for (int j = 0; j < sz; j++)
        if (((j < sz - 1) || growing) && body[j] == key(nx, ny))
          hit = 1'b1;
      if (hit) begin
        m_go   = 1'b1;
        m_pend = (m_pend || g) && !full;
      end else begin
        body.push_front(key(nx, ny));
        if (!growing)
          void'(body.pop_back());
        m_pend = 1'b0;
        exp_mv = 1'b1;
      end
    end else if (g) begin
      m_pend = !full;
    end
  endtask

  task automatic cyc(input bit t, input logic [1:0] d, input bit g, input int qx, input int qy);
    bus.tick      = t;
    bus.direction = d;
    bus.grow      = g;
    bus.query_x   = 5'(qx);
    bus.query_y   = 5'(qy);
    @(posedge clk);
    exp_qh  = 1'b0;
    foreach (body[k])
      if (body[k] == key(qx, qy))
        exp_qh = 1'b1;
    exp_qhd = (body[0] == key(qx, qy));
    model_step(t, d, g);
    #1;
    chk_all();
    bus.tick = 1'b0;
    bus.grow = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.tick = 1'b0;
    bus.grow = 1'b0;
    #1;
    body.delete();
    body.push_back(key(16, 12));
    body.push_back(key(16, 13));
    body.push_back(key(16, 14));
    m_go    = 1'b0;
    m_pend  = 1'b0;
    exp_mv  = 1'b0;
    exp_qh  = 1'b0;
    exp_qhd = 1'b0;
    chk_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] lastd;
    logic [1:0] d;
    bit         t, g;
    int         qx, qy, k;

    bus.tick = 1'b0; bus.direction = U; bus.grow = 1'b0;
    bus.query_x = '0; bus.query_y = '0;
    do_reset();

    // Reset queries
    cyc(0, U, 0, 16, 14);
    cyc(0, U, 0, 16, 12);
    cyc(0, U, 0, 16, 15);

    // Three spaced UP ticks
    repeat (3) begin
      cyc(1, U, 0, 16, 11);
      cyc(0, U, 0, 16, 12);
    end
    chk("tp_up3_head_y", 32'(bus.head_y), 32'd9);

    // Grow alone then tick, then grow coincident with tick
    cyc(0, U, 1, 16, 11);
    cyc(1, U, 0, 16, 11);
    cyc(1, U, 1, 16, 11);
    chk("tp_grow_len", 32'(bus.length), 32'd5);

    // Self collision at length 5
    do_reset();
    cyc(1, U, 1, 16, 13);
    cyc(1, U, 1, 16, 14);
    cyc(1, U, 0, 16, 13);
    cyc(1, R, 0, 16, 9);
    cyc(1, D, 0, 17, 9);
    cyc(1, L, 0, 16, 10);
    chk("tp_self_go", 32'(bus.game_over), 32'd1);
    chk("tp_self_hx", 32'(bus.head_x), 32'd17);
    cyc(1, U, 0, 17, 10);
    cyc(1, R, 0, 16, 10);

    // Tail chase: legal, then with grow pending
    do_reset();
    cyc(1, U, 1, 16, 14);
    cyc(1, R, 0, 16, 11);
    cyc(1, D, 0, 16, 12);
    cyc(1, L, 0, 16, 12);
    chk("tp_tail_go", 32'(bus.game_over), 32'd0);
    chk("tp_tail_hx", 32'(bus.head_x), 32'd16);
    do_reset();
    cyc(1, U, 1, 16, 14);
    cyc(1, R, 0, 16, 11);
    cyc(1, D, 0, 16, 12);
    cyc(0, U, 1, 16, 12);
    cyc(1, L, 0, 16, 12);
    chk("tp_tailgrow_go", 32'(bus.game_over), 32'd1);

    // Wall at the top edge, then asynchronous reset mid-game
    do_reset();
    repeat (12) cyc(1, U, 0, 16, 0);
    cyc(1, U, 0, 16, 0);
    chk("tp_wall_go", 32'(bus.game_over), 32'd1);
    chk("tp_wall_hy", 32'(bus.head_y), 32'd0);
    cyc(0, U, 1, 16, 1);
    do_reset();

    // Saturate at MAX_LEN; grow requests at full length are dropped
    repeat (10) cyc(1, U, 1, 16, 12);
    repeat (10) cyc(1, L, 1, 10, 2);
    chk("tp_maxlen", 32'(bus.length), 32'(ML));
    cyc(0, U, 1, 6, 2);
    cyc(1, L, 0, 5, 2);
    cyc(1, D, 0, 6, 2);

    // Random play
    do_reset();
    lastd = U;
    for (int n = 0; n < 1500; n++) begin
      t = ($urandom_range(0, 2) != 0);
      d = 2'($urandom_range(0, 3));
      if (d == (lastd ^ 2'b01) && ($urandom_range(0, 7) != 0))
        d = lastd;
      g = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        k  = body[$urandom_range(0, body.size() - 1)];
        qx = k / 256;
        qy = k % 256;
      end else begin
        qx = $urandom_range(0, W - 1);
        qy = $urandom_range(0, H - 1);
      end
      cyc(t, d, g, qx, qy);
      if (exp_mv)
        lastd = d;
      if (m_go && ($urandom_range(0, 3) == 0)) begin
        do_reset();
        lastd = U;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Consumer of the 2-bit `direction` code produced by the snake direction controller (UP=00, DOWN=01, LEFT=10, RIGHT=11).
- On each game tick, moves the snake head one grid cell and shifts the body segments behind it.
- Grows the snake on request and detects wall and self collisions.
- Answers registered per-cell "is snake here" queries for the VGA renderer.

Parameters:
GRID_W, 32, grid columns (x = 0..GRID_W-1)
GRID_H, 24, grid rows (y = 0..GRID_H-1, y=0 at top)
XW, 5, x coordinate width (ceil log2 GRID_W)
YW, 5, y coordinate width (ceil log2 GRID_H)
MAX_LEN, 16, segment storage depth
LW, 5, length field width (holds MAX_LEN)
INIT_LEN, 3, length after reset (2..MAX_LEN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle move strobe from game timer
direction  in  2  current heading from direction controller
grow  in  1  one-cycle pulse from food logic: lengthen on the next move
head_x  out  XW  segment 0 x
head_y  out  YW  segment 0 y
length  out  LW  active segment count
game_over  out  1  sticky collision flag
moved  out  1  one-cycle pulse, high the cycle after a successful move
query_x  in  XW  renderer cell x
query_y  in  YW  renderer cell y
query_hit  out  1  registered: query cell is an active segment
query_head  out  1  registered: query cell is the head

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-high.
- Reset values:
  - seg[i] = (GRID_W/2, GRID_H/2 + i) for i < INIT_LEN, so the body trails downward, consistent with the controller's reset heading UP. Remaining seg[i] are set to (0,0).
  - length = INIT_LEN; game_over = 0; moved = 0; query_hit = 0; query_head = 0; grow_pend = 0.
- Heading: UP is y-1, DOWN is y+1, LEFT is x-1, RIGHT is x+1. `direction` is sampled only in a tick cycle. This block does not filter reversals; that is the controller's job.
- grow_pend handling:
  - `grow` sets grow_pend.
  - A grow and a tick in the same cycle: the grow applies to that move.
  - grow_pend clears when consumed by a successful move.
  - grow_pend also clears on a grow request or move made while length == MAX_LEN; that request is dropped.
- Move evaluation, in a tick cycle with game_over = 0:
  - Compute next head nh. Out-of-range detection must use the decrement from 0 and the increment to GRID_W / GRID_H; no wrap-around.
  - Wall: nh outside the grid sets game_over = 1. No segment change, no moved pulse.
  - Self: nh equal to active seg[j] with j < length-1 sets game_over = 1. The tail (j = length-1) is also checked when a growth is applied on this move (grow_pend or grow, with length < MAX_LEN). Otherwise moving into the vacating tail cell is legal.
  - Success: seg[i] <= seg[i-1] for i >= 1 and seg[0] <= nh. length increments if growing and length < MAX_LEN. moved = 1 the next cycle.
- Ticks while game_over = 1 are ignored. game_over stays set until reset.
- Latency:
  - head_x/head_y and length update on the clock edge after the tick cycle.
  - query_hit/query_head are valid one cycle after query_x/query_y are presented. They reflect segment state as of that sampling edge.
  - query_hit = OR over i < length of (seg[i] == query). Segments at index >= length never hit.
- Reset asserted mid-operation immediately forces all reset values, including dropping any pending grow.

Test Plan:
- Reset, no ticks -> head (16,12), length 3, game_over 0. Queries one cycle later: (16,14) hit=1 head=0; (16,12) hit=1 head=1; (16,15) hit=0.
- direction=00, three ticks spaced >= 2 cycles -> head (16,9), three moved pulses. Query (16,11) hit=1, (16,12) hit=0.
- grow pulse alone, then one UP tick -> length 4, head y decrements by 1, previous tail cell still hit. grow coincident with tick -> same result on that tick.
- Self collision at length 5, after reaching head (16,9) moving UP:
  - RIGHT tick -> head (17,9); DOWN tick -> head (17,10).
  - LEFT tick -> nh (16,10) matches seg[3] -> game_over=1, head stays (17,10), no moved pulse, later ticks ignored.
- Tail chase at length 4:
  - From reset, grow+UP tick -> body (16,11),(16,12),(16,13),(16,14).
  - RIGHT tick, then DOWN tick.
  - LEFT tick into the vacating tail (16,12) -> legal: game_over=0, head (16,12). Repeat with grow pending -> game_over=1.
- Wall: from reset, UP ticks until head y=0, one more UP tick -> game_over=1, head (16,0). Then assert reset mid-game -> all reset values restored within the reset cycle, asynchronously.
